// File: rtl/tcb_lite_pkg.sv
// Shared TCB lite definitions.
//   TCB_MOD_SIZ / TCB_MOD_BYT : bus mode selectors (logarithmic size / byte enable)
//   tcb_endian_t              : request endianness
//   siz2byt(siz, off)         : active lane mask for a logarithmic-size access
package tcb_lite_pkg;

  localparam int unsigned TCB_MOD_SIZ = 0;
  localparam int unsigned TCB_MOD_BYT = 1;

  typedef enum logic {
    TCB_LITTLE = 1'b0,
    TCB_BIG    = 1'b1
  } tcb_endian_t;

  // Mask is returned unfolded: bit (off+k) is set for k < 2**siz. Buses up to
  // 64 bits fit in 16 bits; the caller ORs the upper half onto the lower half
  // to wrap lanes within the word.
  function automatic logic [15:0] siz2byt(input logic [2:0] siz, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << (32'd1 << siz)) - 16'd1;
    return m << off;
  endfunction

endpackage

// File: rtl/tcb_lite_lib_lane_map.sv
// Logarithmic-size lane mapping for TCB lite (combinational).
//   siz, off, ndn : request size, byte offset within word, endianness
//   wdt           : LSB-aligned request write data
//   mem_rdt       : full memory word being read
//   msk           : active byte lanes
//   lane_wdt      : write data placed on its memory lanes
//   bus_rdt       : read data gathered back to LSB-aligned bus order
//   mis           : offset not aligned to the access size
module tcb_lite_lib_lane_map
  import tcb_lite_pkg::*;
#(
  parameter int unsigned DAT = 32
) (
  input  logic [$clog2(DAT/8)-1:0] siz,
  input  logic [$clog2(DAT/8)-1:0] off,
  input  logic                     ndn,
  input  logic [DAT-1:0]           wdt,
  input  logic [DAT-1:0]           mem_rdt,
  output logic [DAT/8-1:0]         msk,
  output logic [DAT-1:0]           lane_wdt,
  output logic [DAT-1:0]           bus_rdt,
  output logic                     mis
);

  localparam int unsigned BW = DAT/8;
  localparam int unsigned SW = $clog2(BW);

  logic [15:0]   raw;
  logic [3:0]    num;
  logic [3:0]    pos;
  logic [SW-1:0] lk;
  tcb_endian_t   end_e;

  always_comb begin
    raw      = siz2byt(3'(siz), 3'(off));
    msk      = raw[BW-1:0] | raw[2*BW-1:BW];
    num      = 4'd1 << siz;
    mis      = |(off & SW'(num - 4'd1));
    end_e    = tcb_endian_t'(ndn);
    lane_wdt = '0;
    bus_rdt  = '0;
    pos      = '0;
    lk       = '0;
    // Bus byte k maps to lane off+k (or off+num-1-k for big endian), modulo
    // the word width; the nested loop keeps every select index constant.
    for (int unsigned k = 0; k < BW; k++) begin
      pos = (end_e == TCB_BIG) ? (num - 4'd1 - 4'(k)) : 4'(k);
      lk  = off + SW'(pos);
      for (int unsigned j = 0; j < BW; j++) begin
        if ((4'(k) < num) && (lk == SW'(j))) begin
          lane_wdt[j*8 +: 8] = wdt[k*8 +: 8];
          bus_rdt[k*8 +: 8]  = mem_rdt[j*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/tcb_lite_sub_memory.sv
// TCB lite subordinate memory: byte-addressable RAM with WAIT stall cycles
// before each transfer and responses returned DLY cycles after the transfer.
// Optional macro TCB_LITE_SUB_MEMORY_ALIGN_EN: in MOD=0, accesses not aligned
// to their size raise err (write suppressed, rdt=0); otherwise lanes wrap.
//   clk, rst           : clock, asynchronous active-low reset
//   tcb_vld / tcb_rdy  : request handshake
//   tcb_req_*          : lck (ignored), ndn, wen, adr, siz (MOD=0), byt (MOD=1), wdt
//   tcb_rsp_rdt / _err : response data and bus error
module tcb_lite_sub_memory
  import tcb_lite_pkg::*;
#(
  parameter int unsigned DLY  = 1,
  parameter int unsigned DAT  = 32,
  parameter int unsigned ADR  = 32,
  parameter int unsigned MOD  = 1,
  parameter int unsigned SIZE = 4096,
  parameter int unsigned WAIT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tcb_vld,
  output logic                     tcb_rdy,
  input  logic                     tcb_req_lck,
  input  logic                     tcb_req_ndn,
  input  logic                     tcb_req_wen,
  input  logic [ADR-1:0]           tcb_req_adr,
  input  logic [$clog2(DAT/8)-1:0] tcb_req_siz,
  input  logic [DAT/8-1:0]         tcb_req_byt,
  input  logic [DAT-1:0]           tcb_req_wdt,
  output logic [DAT-1:0]           tcb_rsp_rdt,
  output logic                     tcb_rsp_err
);

  localparam int unsigned BW    = DAT/8;
  localparam int unsigned SW    = $clog2(BW);
  localparam int unsigned AW    = $clog2(SIZE);
  localparam int unsigned WORDS = SIZE/BW;
  localparam int unsigned CW    = (WAIT > 0) ? $clog2(WAIT+1) : 1;

  // handshake / wait states
  logic [CW-1:0] cnt;
  logic          trn;

  assign tcb_rdy = rst & tcb_vld & (cnt == CW'(WAIT));
  assign trn     = tcb_vld & tcb_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (trn || !tcb_vld) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  // addressing
  logic [AW-SW-1:0] idx;
  logic [SW-1:0]    off;
  logic             oor;
  logic             mis;
  logic             err;

  assign idx = tcb_req_adr[AW-1:SW];
  assign off = tcb_req_adr[SW-1:0];
  assign oor = (tcb_req_adr >= ADR'(SIZE));

`ifdef TCB_LITE_SUB_MEMORY_ALIGN_EN
  assign err = oor | mis;
`else
  assign err = oor;
`endif

  // memory array and lane selection
  logic [DAT-1:0] mem [WORDS];
  logic [DAT-1:0] rd_word;
  logic [DAT-1:0] rd_bus;
  logic [DAT-1:0] wr_lane;
  logic [BW-1:0]  msk;

  assign rd_word = mem[idx];

  generate
    if (MOD == TCB_MOD_BYT) begin : g_byt
      assign msk     = tcb_req_byt;
      assign wr_lane = tcb_req_wdt;
      assign rd_bus  = rd_word;
      assign mis     = 1'b0;
    end else begin : g_siz
      tcb_lite_lib_lane_map #(.DAT(DAT)) u_lane_map (
        .siz      (tcb_req_siz),
        .off      (off),
        .ndn      (tcb_req_ndn),
        .wdt      (tcb_req_wdt),
        .mem_rdt  (rd_word),
        .msk      (msk),
        .lane_wdt (wr_lane),
        .bus_rdt  (rd_bus),
        .mis      (mis)
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (trn && tcb_req_wen && !err) begin
      for (int unsigned i = 0; i < BW; i++) begin
        if (msk[i]) mem[idx][i*8 +: 8] <= wr_lane[i*8 +: 8];
      end
    end
  end

  // response stage 0: writes and errored accesses return zero data
  logic [DAT-1:0] s0_rdt;
  logic           s0_err;

  assign s0_rdt = (trn && !tcb_req_wen && !err) ? rd_bus : '0;
  assign s0_err = trn & err;

  generate
    if (DLY == 0) begin : g_comb
      assign tcb_rsp_rdt = s0_rdt;
      assign tcb_rsp_err = s0_err;
    end else begin : g_pipe
      logic [DLY-1:0] vld_q;
      logic [DLY-1:0] err_q;
      logic [DAT-1:0] rdt_q [DLY];
      logic           unused_vld;

      // Stages load only behind a valid stage, so the output holds the last
      // response and reset discards anything still in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
          err_q <= '0;
          for (int unsigned i = 0; i < DLY; i++) rdt_q[i] <= '0;
        end else begin
          vld_q[0] <= trn;
          if (trn) begin
            rdt_q[0] <= s0_rdt;
            err_q[0] <= s0_err;
          end
          for (int unsigned i = 1; i < DLY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
              rdt_q[i] <= rdt_q[i-1];
              err_q[i] <= err_q[i-1];
            end
          end
        end
      end

      assign tcb_rsp_rdt = rdt_q[DLY-1];
      assign tcb_rsp_err = err_q[DLY-1];
      assign unused_vld  = vld_q[DLY-1];
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{tcb_req_lck, tcb_req_siz, tcb_req_ndn, tcb_req_byt, mis};

endmodule
